fft_out_streamer: RTL and testbench
===================================

Name: fft_out_streamer

Overview:
- Unload side of the parallel FFT core interface (fft_radix2/radix4/radix2_2 tops with flat WIDTH*16 buses).
- On the core's done pulse, captures the whole parallel real/imag result into a frame buffer.
- Streams the result one bin per beat over a valid/ready interface, bin 0 first, with index and last.
- Sits between the FFT core and downstream serial consumers (UART/DMA/scope logic).

Parameters:
- WIDTH, 16, signed sample width per real/imag component.
- NPOINT, 16, bins per frame; power of two, >=2.
- IDXW, $clog2(NPOINT), width of the bin index (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_done  in  1  one-cycle pulse from the FFT core; result buses are valid in this cycle.
- fft_real_in  in  WIDTH*NPOINT  flat real result; bin k at [k*WIDTH +: WIDTH].
- fft_imag_in  in  WIDTH*NPOINT  flat imag result, same packing.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_real  out  WIDTH  signed real part of the current bin.
- m_imag  out  WIDTH  signed imaginary part of the current bin.
- m_index  out  IDXW  bin number of the current beat.
- m_last  out  1  high on the beat with m_index == NPOINT-1.
- busy  out  1  frame held or streaming (state != IDLE).
- overrun  out  1  sticky: fft_done arrived while a frame could not be accepted.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst=1): state=IDLE; m_valid=0, m_real=0, m_imag=0, m_index=0, m_last=0, busy=0, overrun=0. Frame buffer contents are don't-care.
- Reset mid-stream aborts the frame immediately. No further beats until the next fft_done after release.
- Transfer occurs on a rising edge with m_valid & m_ready.
- States: IDLE, STREAM.
  - IDLE + fft_done: capture both buses into the buffer, load bin 0 into the output registers, m_valid=1 next cycle, go to STREAM. Latency is done at cycle T, first beat at T+1.
  - STREAM + transfer with index < NPOINT-1: output registers load bin index+1 in the same edge. Full throughput is 1 bin/cycle.
  - STREAM + transfer on the last beat with fft_done low: m_valid=0, go to IDLE.
  - STREAM + transfer on the last beat with fft_done high: capture the new frame and present its bin 0 next cycle. Stay in STREAM; back-to-back frames have no bubble.
  - STREAM + fft_done with no last-beat transfer: new frame dropped, overrun set, current frame continues unaffected.
- While m_valid=1 and m_ready=0, m_real, m_imag, m_index and m_last hold stable.
- m_valid never deasserts without a transfer, except on reset.
- m_last = m_valid & (m_index == NPOINT-1), registered.
- overrun_clr and a new overrun event in the same cycle: set wins.
- No arithmetic on data in the base build; samples pass through bit-exact.

Optional Feature:
- Macro: FFT_OUT_MAG_EN.
- Defined: adds port m_mag out WIDTH+1 (unsigned), an approximate magnitude max(|re|,|im|) + (min(|re|,|im|) >> 1).
  - Computed at WIDTH+1 bits; |-2^(WIDTH-1)| = 2^(WIDTH-1) is representable.
  - Saturates at 2^(WIDTH+1)-1.
  - Registered with the other output fields; same timing, reset value 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_WIDTH=16 and FFT_NPOINT=16 defaults.
  - The bin-slice helper function for [k*WIDTH +: WIDTH].
  - The state encoding localparams (ST_IDLE, ST_STREAM).
- One natural sub-module: fft_mag_approx (combinational abs/max/min/sum with saturation), instantiated only under FFT_OUT_MAG_EN.

Test Plan:
- Impulse-result frame (all 16 bins real=32767, imag=0), m_ready=1: 16 consecutive beats from done+1, m_index 0..15, m_real=32767, m_imag=0, m_last only on index 15, then m_valid=0 and busy=0.
- Ramp frame (bin k real=k, imag=-k) with m_ready toggling 1,0,0,1,...: every beat is delivered in order with no loss or duplication, and fields are stable during stalls.
- fft_done pulsed at beat index 5: overrun=1, the original frame completes intact; overrun_clr pulse then clears it to 0.
- Second fft_done in the cycle of the index-15 transfer: the next cycle shows the new frame's bin 0 with m_valid=1 (no bubble) and overrun stays 0.
- rst asserted at beat index 7: outputs go to 0 immediately; after release, m_valid stays 0 until the next fft_done.
- FFT_OUT_MAG_EN: bin (re=-32768, im=-32768) gives m_mag=49152; bin (re=3, im=-4) gives m_mag=5.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result unload path: default sizes, state
// encoding and the flat-bus bin slice helper.
package fft_pkg;

   localparam int FFT_WIDTH  = 16;
   localparam int FFT_NPOINT = 16;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } fft_state_t;

   // Bin k of a flat default-sized bus lives at [k*FFT_WIDTH +: FFT_WIDTH].
   function automatic logic [FFT_WIDTH-1:0] fft_bin(
      input logic [FFT_WIDTH*FFT_NPOINT-1:0] bus,
      input int unsigned                     k
   );
      return bus[k*FFT_WIDTH +: FFT_WIDTH];
   endfunction

endpackage

// File: rtl/fft_mag_approx.sv
// Approximate complex magnitude max(|re|,|im|) + min(|re|,|im|)/2,
// saturated to WIDTH+1 unsigned bits. Only used when FFT_OUT_MAG_EN is set.
module fft_mag_approx #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] re,
   input  logic signed [WIDTH-1:0] im,
   output logic        [WIDTH:0]   mag
);

   logic [WIDTH:0]   re_ext_s;
   logic [WIDTH:0]   im_ext_s;
   logic [WIDTH:0]   re_abs_s;
   logic [WIDTH:0]   im_abs_s;
   logic [WIDTH:0]   max_s;
   logic [WIDTH:0]   min_s;
   logic [WIDTH+1:0] sum_s;

   // Absolute values carry one extra bit so the most negative input is exact.
   always_comb begin
      re_ext_s = {re[WIDTH-1], re};
      im_ext_s = {im[WIDTH-1], im};
      if (re[WIDTH-1]) begin
         re_abs_s = ~re_ext_s + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         re_abs_s = re_ext_s;
      end
      if (im[WIDTH-1]) begin
         im_abs_s = ~im_ext_s + {{WIDTH{1'b0}}, 1'b1};
      end else begin
         im_abs_s = im_ext_s;
      end
      if (re_abs_s >= im_abs_s) begin
         max_s = re_abs_s;
         min_s = im_abs_s;
      end else begin
         max_s = im_abs_s;
         min_s = re_abs_s;
      end
      sum_s = {1'b0, max_s} + {2'b00, min_s[WIDTH:1]};
      if (sum_s[WIDTH+1]) begin
         mag = {(WIDTH+1){1'b1}};
      end else begin
         mag = sum_s[WIDTH:0];
      end
   end

endmodule

// File: rtl/fft_out_streamer.sv
// Captures a parallel FFT result on fft_done and streams it one bin per beat
// over valid/ready. Define FFT_OUT_MAG_EN to add the m_mag magnitude output.
module fft_out_streamer
   import fft_pkg::*;
#(
   parameter  int WIDTH  = FFT_WIDTH,
   parameter  int NPOINT = FFT_NPOINT,
   localparam int IDXW   = $clog2(NPOINT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fft_done,
   input  logic [WIDTH*NPOINT-1:0]   fft_real_in,
   input  logic [WIDTH*NPOINT-1:0]   fft_imag_in,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [WIDTH-1:0]   m_real,
   output logic signed [WIDTH-1:0]   m_imag,
   output logic [IDXW-1:0]           m_index,
   output logic                      m_last,
`ifdef FFT_OUT_MAG_EN
   output logic [WIDTH:0]            m_mag,
`endif
   output logic                      busy,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPOINT - 1);

   fft_state_t             state_r;
   logic [WIDTH-1:0]       buf_real_r [NPOINT];
   logic [WIDTH-1:0]       buf_imag_r [NPOINT];
   logic                   transfer_s;
   logic                   last_xfer_s;
   logic                   advance_s;
   logic                   capture_s;
   logic                   ovr_set_s;
   logic [IDXW-1:0]        nxt_idx_s;
   logic signed [WIDTH-1:0] nxt_real_s;
   logic signed [WIDTH-1:0] nxt_imag_s;

   // A new frame is only taken when idle or when the last beat leaves this cycle.
   always_comb begin
      transfer_s  = m_valid & m_ready;
      last_xfer_s = transfer_s & m_last;
      advance_s   = transfer_s & ~m_last;
      capture_s   = fft_done & ((state_r == ST_IDLE) | last_xfer_s);
      ovr_set_s   = fft_done & ~capture_s;
      nxt_idx_s   = m_index + IDXW'(1);
   end

   // Selects the sample pair the output registers will present next cycle.
   always_comb begin
      if (capture_s) begin
         nxt_real_s = fft_real_in[WIDTH-1:0];
         nxt_imag_s = fft_imag_in[WIDTH-1:0];
      end else if (advance_s) begin
         nxt_real_s = buf_real_r[nxt_idx_s];
         nxt_imag_s = buf_imag_r[nxt_idx_s];
      end else begin
         nxt_real_s = m_real;
         nxt_imag_s = m_imag;
      end
   end

   // Frame buffer; contents are irrelevant until a capture, so no reset.
   always_ff @(posedge clk) begin
      if (capture_s) begin
         for (int k = 0; k < NPOINT; k++) begin
            buf_real_r[k] <= fft_real_in[k*WIDTH +: WIDTH];
            buf_imag_r[k] <= fft_imag_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // Stream control, output registers and sticky overrun flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         m_valid <= 1'b0;
         m_real  <= '0;
         m_imag  <= '0;
         m_index <= '0;
         m_last  <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         m_real <= nxt_real_s;
         m_imag <= nxt_imag_s;
         if (capture_s) begin
            state_r <= ST_STREAM;
            busy    <= 1'b1;
            m_valid <= 1'b1;
            m_index <= '0;
            m_last  <= 1'b0;
         end else if (advance_s) begin
            m_index <= nxt_idx_s;
            m_last  <= (nxt_idx_s == LAST_IDX);
         end else if (last_xfer_s) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
         if (ovr_set_s) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

`ifdef FFT_OUT_MAG_EN
   logic [WIDTH:0] mag_s;

   fft_mag_approx #(.WIDTH(WIDTH)) u_mag (
      .re  (nxt_real_s),
      .im  (nxt_imag_s),
      .mag (mag_s)
   );

   // Magnitude travels with the sample it was computed from.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mag <= '0;
      end else begin
         m_mag <= mag_s;
      end
   end
`endif

endmodule

// File: tb/tb_fft_out_streamer.sv
// Self-checking bench for fft_out_streamer: queue-based beat model plus
// directed frames with hand-computed literal expectations.
module tb_fft_out_streamer;

   localparam int W = 16;
   localparam int N = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fft_done = 1'b0;
   logic             m_ready = 1'b0;
   logic             overrun_clr = 1'b0;
   logic [W*N-1:0]   fft_real_in = '0;
   logic [W*N-1:0]   fft_imag_in = '0;
   logic             m_valid;
   logic signed [W-1:0] m_real;
   logic signed [W-1:0] m_imag;
   logic [3:0]       m_index;
   logic             m_last;
   logic             busy;
   logic             overrun;
`ifdef FFT_OUT_MAG_EN
   logic [W:0]       m_mag;
`endif

   int errors = 0;
   int checks = 0;
   int q_idx[$];
   int q_re[$];
   int q_im[$];
   bit ovr_m = 1'b0;
   int pops = 0;

   always #5 clk = ~clk;

   fft_out_streamer #(.WIDTH(W), .NPOINT(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .fft_done    (fft_done),
      .fft_real_in (fft_real_in),
      .fft_imag_in (fft_imag_in),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_real      (m_real),
      .m_imag      (m_imag),
      .m_index     (m_index),
      .m_last      (m_last),
`ifdef FFT_OUT_MAG_EN
      .m_mag       (m_mag),
`endif
      .busy        (busy),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mag_ref(input int re, input int im);
      int a, b, mx, mn, s;
      a  = (re < 0) ? -re : re;
      b  = (im < 0) ? -im : im;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      s  = mx + mn / 2;
      if (s > (1 << (W + 1)) - 1) s = (1 << (W + 1)) - 1;
      return s;
   endfunction

   // kind 0 impulse, 1 ramp, 2 offset ramp, 3 scaled, 4 magnitude corners
   task automatic set_frame(input int kind);
      int re, im;
      for (int k = 0; k < N; k++) begin
         case (kind)
            0: begin re = 32767;          im = 0;        end
            1: begin re = k;              im = -k;       end
            2: begin re = 100 + k;        im = k;        end
            3: begin re = -(k + 1) * 10;  im = 1000 + k; end
            default: begin
               if (k == 0)      begin re = -32768; im = -32768; end
               else if (k == 1) begin re = 3;      im = -4;     end
               else             begin re = 7 * k;  im = -3 * k; end
            end
         endcase
         fft_real_in[k*W +: W] = W'(re);
         fft_imag_in[k*W +: W] = W'(im);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      fft_done = 1'b1;
      tick();
      fft_done = 1'b0;
   endtask

   // Model: the outstanding beats of the accepted frame, in order.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q_idx.delete();
         q_re.delete();
         q_im.delete();
         ovr_m = 1'b0;
      end else begin
         bit was_busy, xfer, lastx, set;
         was_busy = (q_idx.size() > 0);
         xfer     = was_busy && m_ready;
         lastx    = xfer && (q_idx.size() == 1);
         set      = 1'b0;
         if (xfer) begin
            void'(q_idx.pop_front());
            void'(q_re.pop_front());
            void'(q_im.pop_front());
            pops++;
         end
         if (fft_done) begin
            if (!was_busy || lastx) begin
               for (int k = 0; k < N; k++) begin
                  q_idx.push_back(k);
                  q_re.push_back(int'($signed(fft_real_in[k*W +: W])));
                  q_im.push_back(int'($signed(fft_imag_in[k*W +: W])));
               end
            end else begin
               set = 1'b1;
            end
         end
         if (set) ovr_m = 1'b1;
         else if (overrun_clr) ovr_m = 1'b0;
      end
   end

   // Compare the DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      bit exp_v;
      exp_v = (q_idx.size() > 0);
      chk("m_valid", m_valid, exp_v);
      chk("busy", busy, exp_v);
      chk("overrun", overrun, ovr_m);
      if (rst) begin
         chk("rst_real", m_real, 0);
         chk("rst_imag", m_imag, 0);
         chk("rst_index", m_index, 0);
      end
      if (exp_v) begin
         chk("m_index", m_index, q_idx[0]);
         chk("m_real", m_real, q_re[0]);
         chk("m_imag", m_imag, q_im[0]);
         chk("m_last", m_last, q_idx[0] == N - 1);
`ifdef FFT_OUT_MAG_EN
         chk("m_mag", m_mag, mag_ref(q_re[0], q_im[0]));
`endif
      end else begin
         chk("m_last_idle", m_last, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0, c;
      bit seen5;
      repeat (2) tick();
      chk("reset_valid", m_valid, 0);
      chk("reset_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // Impulse frame, full throughput
      set_frame(0);
      m_ready = 1'b1;
      p0 = pops;
      pulse_done();
      chk("imp_first_valid", m_valid, 1);
      chk("imp_first_index", m_index, 0);
      chk("imp_first_real", m_real, 32767);
      repeat (15) tick();
      chk("imp_last_index", m_index, 15);
      chk("imp_last_flag", m_last, 1);
      tick();
      chk("imp_end_valid", m_valid, 0);
      chk("imp_end_busy", busy, 0);
      chk("imp_beats", pops - p0, 16);

      // Ramp frame with ready pattern 1,0,0 repeating
      set_frame(1);
      p0 = pops;
      seen5 = 1'b0;
      pulse_done();
      chk("ramp_first_real", m_real, 0);
      c = 0;
      while ((q_idx.size() > 0) && (c < 100)) begin
         m_ready = (c % 3 == 0);
         if (m_valid && m_index == 4'd5) begin
            seen5 = 1'b1;
            chk("ramp_bin5_imag", m_imag, -5);
         end
         tick();
         c++;
      end
      chk("ramp_drained", q_idx.size(), 0);
      chk("ramp_beats", pops - p0, 16);
      chk("ramp_saw_bin5", seen5, 1);
      m_ready = 1'b1;
      tick();

      // fft_done mid-frame is dropped and flagged
      set_frame(2);
      pulse_done();
      repeat (5) tick();
      chk("ovr_at_index", m_index, 5);
      set_frame(3);
      pulse_done();
      chk("ovr_set", overrun, 1);
      chk("ovr_cont_index", m_index, 6);
      chk("ovr_cont_real", m_real, 106);
      repeat (10) tick();
      chk("ovr_end_valid", m_valid, 0);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Back-to-back frames without a bubble
      set_frame(2);
      pulse_done();
      repeat (15) tick();
      chk("b2b_at_last", m_last, 1);
      set_frame(3);
      pulse_done();
      chk("b2b_valid", m_valid, 1);
      chk("b2b_index", m_index, 0);
      chk("b2b_real", m_real, -10);
      chk("b2b_overrun", overrun, 0);
      repeat (16) tick();
      chk("b2b_end_valid", m_valid, 0);

      // Reset in the middle of a frame
      set_frame(1);
      pulse_done();
      repeat (7) tick();
      chk("rst_at_index", m_index, 7);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", m_valid, 0);
      chk("rst_mid_index", m_index, 0);
      chk("rst_mid_real", m_real, 0);
      chk("rst_mid_busy", busy, 0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("rst_after_valid", m_valid, 0);

`ifdef FFT_OUT_MAG_EN
      set_frame(4);
      pulse_done();
      chk("mag_min_min", m_mag, 49152);
      tick();
      chk("mag_3_m4", m_mag, 5);
      repeat (15) tick();
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
